// File: rtl/matrix_pkg.sv
// Shared constants, stream FSM states and a flat-vector element accessor
// for the matrix_mul family (operand side, multiplier, result streamer).
package matrix_pkg;

  localparam int ELEM_W = 32;
  localparam int N_ELEM = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CSUM   = 2'd2
  } state_t;

  // Element 0 sits in the MSBs of the flat vector.
  function automatic logic [ELEM_W-1:0] get_elem(input logic [ELEM_W*N_ELEM-1:0] vec,
                                                 input int unsigned k);
    return vec[ELEM_W*(N_ELEM-1-int'(k)) +: ELEM_W];
  endfunction

endpackage

// File: rtl/matrix_result_streamer.sv
// Captures a flat matrix_mul result and streams it one element per beat.
// Define MATRIX_STREAM_CHECKSUM_EN to append a modulo-2^ELEM_W sum beat.
module matrix_result_streamer #(
  parameter int ELEM_W = matrix_pkg::ELEM_W,
  parameter int N_ELEM = matrix_pkg::N_ELEM
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [ELEM_W*N_ELEM-1:0] result_in,
  output logic                     busy,
  output logic [ELEM_W-1:0]        out_data,
  output logic [3:0]               out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     done
);
  import matrix_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(N_ELEM-1);

  state_t                     state_q, state_d;
  logic [3:0]                 idx_q, idx_d;
  logic [ELEM_W*N_ELEM-1:0]   frame_q, frame_d;
  logic                       done_q, done_d;
  logic                       hs;
`ifdef MATRIX_STREAM_CHECKSUM_EN
  logic [ELEM_W-1:0]          csum_q, csum_d, csum_in;

  // Sum is formed from the live input at capture so the extra beat costs no latency.
  always_comb begin
    csum_in = '0;
    for (int k = 0; k < N_ELEM; k++) csum_in = csum_in + result_in[ELEM_W*k +: ELEM_W];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
`ifdef MATRIX_STREAM_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      done_q  <= done_d;
`ifdef MATRIX_STREAM_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign hs = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    done_d  = 1'b0;
`ifdef MATRIX_STREAM_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          frame_d = result_in;
          idx_d   = '0;
          state_d = STREAM;
`ifdef MATRIX_STREAM_CHECKSUM_EN
          csum_d  = csum_in;
`endif
        end
      end
      STREAM: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef MATRIX_STREAM_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      CSUM: begin
        if (hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Everything below decodes registered state only; out_ready never reaches out_valid.
  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == STREAM) || (state_q == CSUM);
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    done      = done_q;
    case (state_q)
      STREAM: begin
        out_data  = frame_q[ELEM_W*(N_ELEM-1-int'(idx_q)) +: ELEM_W];
        out_index = idx_q;
`ifndef MATRIX_STREAM_CHECKSUM_EN
        out_last  = (idx_q == LAST_IDX);
`endif
      end
`ifdef MATRIX_STREAM_CHECKSUM_EN
      CSUM: begin
        out_data = csum_q;
        out_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: directed table, corner
// sequences and randomized traffic against a beat-queue reference model.
module tb_matrix_result_streamer;
  localparam int EW = 32;
  localparam int NE = 16;
`ifdef MATRIX_STREAM_CHECKSUM_EN
  localparam int NROWS = NE + 3;
`else
  localparam int NROWS = NE + 2;
`endif

  logic           clk = 1'b0;
  logic           reset, load, out_ready;
  logic [EW*NE-1:0] result_in;
  logic           busy, out_valid, out_last, done;
  logic [EW-1:0]  out_data;
  logic [3:0]     out_index;

  always #5 clk = ~clk;

  matrix_result_streamer dut (
    .clk(clk), .reset(reset), .load(load), .result_in(result_in),
    .busy(busy), .out_data(out_data), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just a list of beats to emit in order.
  logic [EW-1:0] stim_e[NE];
  logic [EW-1:0] m_beats[$];
  int            m_pos;
  bit            m_active, m_done;

  task automatic pack_stim();
    for (int k = 0; k < NE; k++) result_in[EW*(NE-1-k) +: EW] = stim_e[k];
  endtask

  task automatic set_stim(input int mode);
    for (int k = 0; k < NE; k++)
      case (mode)
        0: stim_e[k] = EW'(k + 1);
        1: stim_e[k] = 32'hFFFF_FFFF;
        2: stim_e[k] = EW'(2 * k);
        3: stim_e[k] = EW'(100 + k);
        default: stim_e[k] = $urandom;
      endcase
    pack_stim();
  endtask

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_pos    = 0;
    m_beats.delete();
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_active);
    chk("valid", out_valid, m_active);
    chk("done", done, m_done);
    if (m_active) begin
      chk("data", out_data, m_beats[m_pos]);
      chk("index", out_index, (m_pos < NE) ? m_pos : 0);
      chk("last", out_last, m_pos == m_beats.size() - 1);
    end
  endtask

  // Called at a negedge: check current outputs, drive inputs, advance model, clock.
  task automatic step(input bit ld, input bit rdy);
    bit hs, acc;
    logic [EW-1:0] sum;
    check_outputs();
    load      = ld;
    out_ready = rdy;
    hs  = m_active && rdy;
    acc = !m_active && ld;
    m_done = hs && (m_pos == m_beats.size() - 1);
    if (hs) begin
      m_pos++;
      if (m_pos == m_beats.size()) m_active = 0;
    end
    if (acc) begin
      m_beats.delete();
      sum = '0;
      for (int k = 0; k < NE; k++) begin
        m_beats.push_back(stim_e[k]);
        sum = sum + stim_e[k];
      end
`ifdef MATRIX_STREAM_CHECKSUM_EN
      m_beats.push_back(sum);
`endif
      m_pos    = 0;
      m_active = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_active || m_done) && n < 200) begin
      step(1'b0, 1'b1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain: frame still active after %0d cycles", n);
    end
  endtask

  task automatic do_reset_check();
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit            ld;
    bit            rdy;
    bit            v;
    logic [EW-1:0] d;
    logic [3:0]    idx;
    bit            last;
    bit            dn;
    bit            bsy;
  } row_t;
  row_t tbl[NROWS];

  initial begin
    // Basic frame 1..16 with out_ready held high, expected outputs per cycle.
    tbl[0] = '{ld: 1, rdy: 1, v: 0, d: 0, idx: 0, last: 0, dn: 0, bsy: 0};
    for (int r = 1; r <= NE; r++)
      tbl[r] = '{ld: 0, rdy: 1, v: 1, d: EW'(r), idx: 4'(r - 1), last: 0, dn: 0, bsy: 1};
`ifdef MATRIX_STREAM_CHECKSUM_EN
    tbl[NE+1] = '{ld: 0, rdy: 1, v: 1, d: 32'h88, idx: 0, last: 1, dn: 0, bsy: 1};
`else
    tbl[NE].last = 1;
`endif
    tbl[NROWS-1] = '{ld: 0, rdy: 1, v: 0, d: 0, idx: 0, last: 0, dn: 1, bsy: 0};

    reset = 1'b1; load = 1'b0; out_ready = 1'b0; result_in = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset_check();

    set_stim(0);
    for (int r = 0; r < NROWS; r++) begin
      chk("tbl_valid", out_valid, tbl[r].v);
      chk("tbl_busy", busy, tbl[r].bsy);
      chk("tbl_done", done, tbl[r].dn);
      if (tbl[r].v) begin
        chk("tbl_data", out_data, tbl[r].d);
        chk("tbl_index", out_index, tbl[r].idx);
        chk("tbl_last", out_last, tbl[r].last);
      end
      load = tbl[r].ld;
      out_ready = tbl[r].rdy;
      @(posedge clk);
      @(negedge clk);
    end
    load = 1'b0;
    model_reset();

    // Backpressure 1,0,0,1 repeating; stall stability follows from the model.
    set_stim(0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && (m_active || m_done); i++)
      step(1'b0, (i % 4 == 0) || (i % 4 == 3));
    step(1'b0, 1'b0);

    // Load while busy at beat 5 must be ignored.
    set_stim(0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && (m_active || m_done); i++) begin
      if (m_pos == 5 && m_active) begin
        set_stim(1);
        step(1'b1, 1'b1);
      end else begin
        step(1'b0, 1'b1);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // Reset at beat 8, then a fresh 2k frame.
    set_stim(0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 50 && m_pos < 8; i++) step(1'b0, 1'b1);
    do_reset_check();
    set_stim(2);
    step(1'b1, 1'b1);
    drain();

    // Back-to-back: load in the done cycle.
    set_stim(0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && !m_done; i++) step(1'b0, 1'b1);
    chk("b2b_done_seen", m_done, 1);
    set_stim(3);
    step(1'b1, 1'b1);
    chk("b2b_first_valid", out_valid, 1);
    chk("b2b_first_data", out_data, 100);
    drain();

`ifdef MATRIX_STREAM_CHECKSUM_EN
    set_stim(1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && m_pos < NE; i++) step(1'b0, 1'b1);
    chk("csum_all_ones", out_data, 32'hFFFF_FFF0);
    chk("csum_last", out_last, 1);
    drain();
`endif

    // Randomized traffic with changing inputs, random loads and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) set_stim(9);
      if ($urandom_range(0, 599) == 0) do_reset_check();
      else step($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    drain();
    step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
